// File: rtl/icache_axi_rd_bridge_pkg.sv
// icache_axi_rd_bridge shared types
// FSM states, AXI encodings, line offset helper
package icache_axi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    R     = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // byte-offset bits inside one cache line
  function automatic int line_off_bits(input int beats, input int data_wd);
    return $clog2(beats * data_wd / 8);
  endfunction

endpackage

// File: rtl/icache_axi_rd_bridge_if.sv
// icache_axi_rd_bridge bus bundle
// cache SRAM-style port plus AXI4 AR/R channels
interface icache_axi_rd_bridge_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 64
);
  logic               flush;
  logic               sram_req;
  logic               sram_ready;
  logic [ADDR_WD-1:0] sram_addr;
  logic [DATA_WD-1:0] sram_rdata;
  logic               sram_valid;
  logic               sram_err;

  logic               arvalid;
  logic               arready;
  logic [ADDR_WD-1:0] araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic [3:0]         arid;

  logic               rvalid;
  logic               rready;
  logic [DATA_WD-1:0] rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic [3:0]         rid;

  // bridge side
  modport master (
    input  flush, sram_req, sram_addr,
    output sram_ready, sram_rdata, sram_valid, sram_err,
    output arvalid, araddr, arlen, arsize, arburst, arid,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  // cache + AXI slave side
  modport slave (
    output flush, sram_req, sram_addr,
    input  sram_ready, sram_rdata, sram_valid, sram_err,
    input  arvalid, araddr, arlen, arsize, arburst, arid,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge: line refill -> one AXI4 INCR read burst
// beats forwarded one cycle late; flush drains the burst silently
import icache_axi_pkg::*;

module icache_axi_rd_bridge #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 64,
  parameter int BEATS   = 2
) (
  input logic                    clk,
  input logic                    reset,
  icache_axi_rd_bridge_if.master bus
);

  localparam int OFF_WD = line_off_bits(BEATS, DATA_WD);
  localparam int CNT_WD = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_WD-1:0] CNT_MAX = CNT_WD'(BEATS - 1);
  localparam logic [7:0] ARLEN  = 8'(BEATS - 1);
  localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WD / 8));

  state_e state_q, state_d;

  logic [ADDR_WD-1:0] araddr_q, araddr_d;
  logic [CNT_WD-1:0]  cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               fl_q, fl_d;
  logic [DATA_WD-1:0] rdata_q, rdata_d;
  logic               valid_q, valid_d;
  logic               serr_q, serr_d;

  logic ready_w;
  logic accept;
  logic beat;
  logic err_now;
  logic unused_rid;

  assign unused_rid = ^bus.rid;

  assign ready_w = (state_q == IDLE) & ~bus.flush & ~reset;
  assign accept  = ready_w & bus.sram_req;
  assign beat    = ((state_q == R) | (state_q == DRAIN)) & bus.rvalid;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: burst always ends on rlast
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = AR;
      end
      AR: begin
        if (bus.arready) begin
          state_d = (fl_q | bus.flush) ? DRAIN : R;
        end
      end
      R: begin
        if (bus.rvalid & bus.rlast) state_d = IDLE;
        else if (bus.flush)         state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.rvalid & bus.rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and constant AR attributes
  always_comb begin
    bus.arvalid    = (state_q == AR);
    bus.rready     = (state_q == R) | (state_q == DRAIN);
    bus.sram_ready = ready_w;
    bus.araddr     = araddr_q;
    bus.arlen      = ARLEN;
    bus.arsize     = ARSIZE;
    bus.arburst    = AXI_BURST_INCR;
    bus.arid       = 4'd0;
    bus.sram_rdata = rdata_q;
    bus.sram_valid = valid_q;
    bus.sram_err   = serr_q;
  end

  // request capture, beat counting, error tracking, beat forwarding
  always_comb begin
    araddr_d = araddr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fl_d     = fl_q;
    rdata_d  = rdata_q;
    valid_d  = 1'b0;
    serr_d   = 1'b0;
    err_now  = err_q
             | (bus.rresp != AXI_RESP_OKAY)
             | (bus.rlast != (cnt_q == CNT_MAX));
    if (accept) begin
      araddr_d = {bus.sram_addr[ADDR_WD-1:OFF_WD], {OFF_WD{1'b0}}};
      cnt_d    = '0;
      err_d    = 1'b0;
      fl_d     = 1'b0;
    end
    if (state_q == AR) begin
      fl_d = fl_q | bus.flush;
    end
    if (beat) begin
      err_d = err_now;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if ((state_q == R) & ~bus.flush) begin
        valid_d = 1'b1;
        rdata_d = bus.rdata;
        serr_d  = bus.rlast & err_now;
      end
    end
  end

  // datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      araddr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      fl_q     <= 1'b0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      araddr_q <= araddr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fl_q     <= fl_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      serr_q   <= serr_d;
    end
  end

endmodule
